// File: rtl/dual_issue_ctrl_pkg.sv
// spu_issue_pkg: shared states, pipe encoding and NOP encodings for the issue scheduler.
package spu_issue_pkg;
    typedef enum logic [1:0] {EMPTY, PAIR, SECOND} issue_state_t;
    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} pipe_t;
    localparam logic [31:0] NOP_EVEN = 32'h4020_0000;
    localparam logic [31:0] NOP_ODD  = 32'h0020_0000;
endpackage

// File: rtl/dual_issue_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: buffers one fetched pair and issues it to the even/odd pipes,
// padding with nop/lnop on stalls, same-pipe conflicts and intra-pair dependences.
module dual_issue_ctrl
    import spu_issue_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_instr0,
    input  logic [31:0]      fetch_instr1,
    input  logic [PC_W-1:0]  fetch_pc,
    input  logic             fetch_v1,
    output logic [31:0]      cand_instr0,
    output logic [31:0]      cand_instr1,
    input  logic             cand_odd0,
    input  logic             cand_odd1,
    input  logic             cand_dep,
    input  logic             stall_even_raw,
    input  logic             stall_odd_raw,
    input  logic             branch_taken,
    output logic [31:0]      instr_even,
    output logic [31:0]      instr_odd,
    output logic [PC_W-1:0]  pc,
    output logic             first_odd,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    issue_state_t    state, state_nxt;
    logic [PC_W-1:0] buf_pc, pc_nxt;
    logic            buf_v1;
    pipe_t           p0, p1;
    logic            stall0, stall1, iss0, pair1, iss1, all_done, accept;
    logic [31:0]     even_nxt, odd_nxt;
    logic            fo_nxt, stall_inc;

    assign p0     = pipe_t'(cand_odd0);
    assign p1     = pipe_t'(cand_odd1);
    assign stall0 = (p0 == ODD) ? stall_odd_raw : stall_even_raw;
    assign stall1 = (p1 == ODD) ? stall_odd_raw : stall_even_raw;

    always_comb begin
        iss0        = state == PAIR && !stall0 && !branch_taken;
        pair1       = iss0 && buf_v1 && cand_odd1 != cand_odd0 && !cand_dep && !stall1;
        iss1        = pair1 || (state == SECOND && !stall1 && !branch_taken);
        all_done    = iss0 && (pair1 || !buf_v1);
        fetch_ready = !branch_taken && (state == EMPTY || all_done);
        accept      = fetch_valid && fetch_ready;
        stall_inc   = !branch_taken && ((state == PAIR && stall0) || (state == SECOND && stall1));
        state_nxt   = state;
        if (branch_taken)
            state_nxt = EMPTY;
        else if (state == EMPTY || all_done)
            state_nxt = accept ? PAIR : EMPTY;
        else if (iss0)
            state_nxt = SECOND;
        else if (iss1)
            state_nxt = EMPTY;
        even_nxt = NOP_EVEN;
        odd_nxt  = NOP_ODD;
        pc_nxt   = pc;
        fo_nxt   = 1'b0;
        if (iss0 && p0 == ODD) begin
            odd_nxt = cand_instr0;
            pc_nxt  = buf_pc;
            fo_nxt  = 1'b1;
        end else if (iss0) begin
            even_nxt = cand_instr0;
        end
        if (iss1 && p1 == ODD) begin
            odd_nxt = cand_instr1;
            pc_nxt  = buf_pc + PC_W'(1);
        end else if (iss1) begin
            even_nxt = cand_instr1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            cand_instr0 <= '0;
            cand_instr1 <= '0;
            buf_pc      <= '0;
            buf_v1      <= 1'b0;
            instr_even  <= NOP_EVEN;
            instr_odd   <= NOP_ODD;
            pc          <= '0;
            first_odd   <= 1'b0;
        end else begin
            state      <= state_nxt;
            instr_even <= even_nxt;
            instr_odd  <= odd_nxt;
            pc         <= pc_nxt;
            first_odd  <= fo_nxt;
            if (accept) begin
                cand_instr0 <= fetch_instr0;
                cand_instr1 <= fetch_instr1;
                buf_pc      <= fetch_pc;
                buf_v1      <= fetch_v1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_dual_cnt (
        .clk(clk), .reset(reset), .inc(pair1), .cnt(dual_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_inc), .cnt(stall_cnt)
    );
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb_dual_issue_ctrl: directed pair sequences; expected issue state is queued per edge
// and a monitor compares it against the registered outputs after each clock.
module tb_dual_issue_ctrl;
    localparam logic [31:0] NE = 32'h4020_0000;
    localparam logic [31:0] NO = 32'h0020_0000;

    logic        clk = 1'b0;
    logic        reset, fetch_valid, fetch_ready, fetch_v1;
    logic [31:0] fetch_instr0, fetch_instr1, cand_instr0, cand_instr1;
    logic [7:0]  fetch_pc, pc;
    logic        cand_odd0, cand_odd1, cand_dep, stall_even_raw, stall_odd_raw, branch_taken;
    logic [31:0] instr_even, instr_odd;
    logic        first_odd;
    logic [15:0] dual_cnt, stall_cnt;

    typedef struct {
        logic [31:0] e;
        logic [31:0] o;
        logic [7:0]  p;
        logic        fo;
        logic [15:0] dc;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    dual_issue_ctrl #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
        .fetch_pc(fetch_pc), .fetch_v1(fetch_v1),
        .cand_instr0(cand_instr0), .cand_instr1(cand_instr1),
        .cand_odd0(cand_odd0), .cand_odd1(cand_odd1), .cand_dep(cand_dep),
        .stall_even_raw(stall_even_raw), .stall_odd_raw(stall_odd_raw),
        .branch_taken(branch_taken),
        .instr_even(instr_even), .instr_odd(instr_odd), .pc(pc), .first_odd(first_odd),
        .dual_cnt(dual_cnt), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are already driven; check fetch_ready, queue post-edge expectations, take the edge.
    task automatic step(input logic rdy, input logic [31:0] e, input logic [31:0] o,
                        input logic [7:0] p, input logic fo, input logic [15:0] dc,
                        input logic [15:0] sc);
        exp_t x;
        #2;
        chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, rdy});
        x.e = e; x.o = o; x.p = p; x.fo = fo; x.dc = dc; x.sc = sc;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i0, input logic [31:0] i1, input logic [7:0] a,
                         input logic v1);
        fetch_valid = 1'b1; fetch_instr0 = i0; fetch_instr1 = i1; fetch_pc = a; fetch_v1 = v1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("instr_even", instr_even, x.e);
                chk("instr_odd", instr_odd, x.o);
                chk("pc", {24'b0, pc}, {24'b0, x.p});
                chk("first_odd", {31'b0, first_odd}, {31'b0, x.fo});
                chk("dual_cnt", {16'b0, dual_cnt}, {16'b0, x.dc});
                chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, x.sc});
            end
        end
    end

    initial begin : watchdog
        #20000;
        if (!done) begin
            $display("FAIL watchdog: run did not complete, got timeout, expected finish");
            $fatal(1, "timeout");
        end
    end

    initial begin : stim
        reset = 1'b1; fetch_valid = 1'b0; fetch_instr0 = '0; fetch_instr1 = '0;
        fetch_pc = '0; fetch_v1 = 1'b1; cand_odd0 = 1'b0; cand_odd1 = 1'b1; cand_dep = 1'b0;
        stall_even_raw = 1'b0; stall_odd_raw = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        // reset held two cycles
        step(1, NE, NO, 8'd0, 0, 0, 0);
        step(1, NE, NO, 8'd0, 0, 0, 0);
        chk("reset cand_instr0", cand_instr0, 32'h0);
        reset = 1'b0;
        // even a + odd lqd at pc 8: dual issue
        offer(32'h1800_0000, 32'h3400_0000, 8'd8, 1);
        step(1, NE, NO, 8'd0, 0, 0, 0);
        chk("cand_instr0 after accept", cand_instr0, 32'h1800_0000);
        fetch_valid = 1'b0; cand_odd0 = 1'b0; cand_odd1 = 1'b1;
        step(1, 32'h1800_0000, 32'h3400_0000, 8'd9, 0, 1, 0);
        // both even: slot 0 then slot 1, lnop each time
        offer(32'h1800_0010, 32'h1800_0020, 8'd16, 1);
        step(1, NE, NO, 8'd9, 0, 1, 0);
        fetch_valid = 1'b0; cand_odd0 = 1'b0; cand_odd1 = 1'b0;
        step(0, 32'h1800_0010, NO, 8'd9, 0, 1, 0);
        step(0, 32'h1800_0020, NO, 8'd9, 0, 1, 0);
        // odd slot 0, even slot 1, dependent
        offer(32'h3400_0100, 32'h1800_0030, 8'd32, 1);
        step(1, NE, NO, 8'd9, 0, 1, 0);
        fetch_valid = 1'b0; cand_odd0 = 1'b1; cand_odd1 = 1'b0; cand_dep = 1'b1;
        step(0, NE, 32'h3400_0100, 8'd32, 1, 1, 0);
        step(0, 32'h1800_0030, NO, 8'd32, 0, 1, 0);
        cand_dep = 1'b0;
        // even RAW stall held three cycles
        offer(32'h1800_0040, 32'h3400_0200, 8'd40, 1);
        step(1, NE, NO, 8'd32, 0, 1, 0);
        fetch_valid = 1'b0; cand_odd0 = 1'b0; cand_odd1 = 1'b1; stall_even_raw = 1'b1;
        step(0, NE, NO, 8'd32, 0, 1, 1);
        step(0, NE, NO, 8'd32, 0, 1, 2);
        step(0, NE, NO, 8'd32, 0, 1, 3);
        stall_even_raw = 1'b0;
        // issue on the 4th edge while accepting the next pair (back-to-back)
        offer(32'h1800_0050, 32'h3400_0300, 8'd48, 1);
        step(1, 32'h1800_0040, 32'h3400_0200, 8'd41, 0, 2, 3);
        offer(32'h1800_0060, 32'h3400_0400, 8'd50, 1);
        step(1, 32'h1800_0050, 32'h3400_0300, 8'd49, 0, 3, 3);
        // slot 1 odd stalled -> SECOND; not a stall of the oldest slot
        fetch_valid = 1'b0; stall_odd_raw = 1'b1;
        step(0, 32'h1800_0060, NO, 8'd49, 0, 3, 3);
        // branch in SECOND with a pair offered
        stall_odd_raw = 1'b0; branch_taken = 1'b1;
        offer(32'h1800_0070, 32'h3400_0500, 8'd60, 1);
        step(0, NE, NO, 8'd49, 0, 3, 3);
        chk("cand_instr0 not loaded on branch", cand_instr0, 32'h1800_0060);
        branch_taken = 1'b0;
        step(1, NE, NO, 8'd49, 0, 3, 3);
        chk("cand_instr0 after branch", cand_instr0, 32'h1800_0070);
        fetch_valid = 1'b0;
        step(1, 32'h1800_0070, 32'h3400_0500, 8'd61, 0, 4, 3);
        // invalid slot 1: slot 0 alone completes the pair
        offer(32'h3400_0600, 32'h0, 8'd64, 0);
        step(1, NE, NO, 8'd61, 0, 4, 3);
        fetch_valid = 1'b0; cand_odd0 = 1'b1; cand_odd1 = 1'b0;
        step(1, NE, 32'h3400_0600, 8'd64, 1, 4, 3);
        // reset mid-pair discards the buffer
        offer(32'h1800_0080, 32'h3400_0700, 8'd70, 1);
        cand_odd0 = 1'b0; cand_odd1 = 1'b1;
        step(1, NE, NO, 8'd64, 0, 4, 3);
        fetch_valid = 1'b0; reset = 1'b1;
        step(1, NE, NO, 8'd0, 0, 0, 0);
        chk("cand_instr0 after reset", cand_instr0, 32'h0);
        reset = 1'b0;
        step(1, NE, NO, 8'd0, 0, 0, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard drained", q.size(), 32'd0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dual_issue_ctrl.md
# dual_issue_ctrl

Issue scheduler sitting between fetch/decode and the even/odd execution pipes. It buffers one fetched instruction pair, decides each cycle which instructions issue to the even and odd pipes, and inserts `nop`/`lnop` on stalls, structural conflicts and intra-pair dependences. It flushes its buffer when a branch is taken. It drives the `instr_even`/`instr_odd`/`pc`/`first_odd` inputs of the pipe datapath and consumes that datapath's `stall_*_raw` and `branch_taken` outputs.

## Interface
Parameters:
- `PC_W`, 8: word-address width of program counter.
- `CNT_W`, 16: width of performance counters.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `fetch_valid`  in  1  pair offered by fetch.
- `fetch_ready`  out  1  pair accepted on this edge when `fetch_valid & fetch_ready`.
- `fetch_instr0`, `fetch_instr1`  in  32 each  older/younger instruction of the pair.
- `fetch_pc`  in  PC_W  word address of `fetch_instr0`; bit 0 always 0.
- `fetch_v1`  in  1  slot 1 valid (0 when a branch target lands on the odd word).
- `cand_instr0`, `cand_instr1`  out  32 each  buffered pair, driven to decoder/hazard logic.
- `cand_odd0`, `cand_odd1`  in  1 each  decoder: slot targets odd pipe.
- `cand_dep`  in  1  decoder: slot 1 reads slot 0's rt.
- `stall_even_raw`, `stall_odd_raw`  in  1 each  RAW hazard on candidate for that pipe.
- `branch_taken`  in  1  flush request from odd pipe.
- `instr_even`, `instr_odd`  out  32 each  registered issue to pipes.
- `pc`  out  PC_W  registered word address of the issued odd instruction.
- `first_odd`  out  1  issued odd instruction is older than the issued even instruction.
- `dual_cnt`, `stall_cnt`  out  CNT_W each  saturating counts of dual-issue cycles and of cycles where a valid candidate was held by a RAW stall.

## Operation
- Buffer states: `EMPTY`, `PAIR` (both slots pending), `SECOND` (slot 0 issued, slot 1 pending).
- `fetch_ready` is 1 when the state is `EMPTY`, or when the state is `PAIR` and this edge issues all pending slots. It is 0 when `branch_taken`=1.
- PAIR issue rules:
  - slot 0 issues iff its pipe is not stalled.
  - slot 1 issues with it iff `fetch_v1`=1, `cand_odd1`≠`cand_odd0`, `cand_dep`=0 and slot 1's pipe is not stalled.
  - Slot 1 never issues before slot 0.
  - An invalid slot 1 counts as issued.
- PAIR transitions:
  - slot 0 blocked → stay in PAIR.
  - slot 0 only issued → SECOND.
  - all issued → EMPTY, or PAIR if a new pair is accepted on the same edge.
- SECOND: slot 1 issues iff its pipe is not stalled, then → EMPTY. In SECOND, `cand_dep` is ignored.
- Unused pipe slots are loaded with `NOP_EVEN`=32'h4020_0000 or `NOP_ODD`=32'h0020_0000.
- `pc` = buffered pair pc + slot index of the issued odd instruction. It holds its previous value when `lnop` is issued.
- `first_odd`=1 iff the odd pipe receives slot 0, including the case where slot 0 issues alone.
- `branch_taken`:
  - buffer → EMPTY and the pending pair is discarded.
  - the issue registers load both NOPs on that edge.
  - an offered fetch pair is not accepted.
- `stall_cnt` increments when a stall blocks the oldest pending slot. Both counters saturate at all-ones.

## Timing
- Reset values: state EMPTY, `instr_even`=`NOP_EVEN`, `instr_odd`=`NOP_ODD`, `pc`=0, `first_odd`=0, counters 0, `fetch_ready`=1, `cand_instr*`=0.
- Latency:
  - pair accepted at edge N is visible on `cand_*` after N.
  - earliest issue is at edge N+1; `instr_*` are valid after N+1.
- Stall and decoder inputs are same-cycle combinational functions of `cand_*` and are sampled at the edge.
- `branch_taken` has priority over issue and over fetch acceptance.
- `reset` has priority over `branch_taken`. Reset mid-pair discards the buffer.
- Back-to-back dual issue sustains one pair per cycle.

## Structure
- Package `spu_issue_pkg`: `issue_state_t` enum, `NOP_EVEN`, `NOP_ODD`, `pipe_t` (EVEN=0, ODD=1).
- One sub-module, `sat_counter` (parameter `CNT_W`, inputs `inc` and `reset`), instantiated twice.

## Test plan
- Reset asserted 2 cycles → both NOPs, `pc`=0, `fetch_ready`=1, counters 0.
- Pair {even `a` (32'h1800_0000), odd `lqd`} at pc 8, no dependence → one edge later `instr_even`=`a`, `instr_odd`=`lqd`, `pc`=9, `first_odd`=0, `dual_cnt`=1.
- Pair with both slots even → cycle 1 issues slot 0 + `lnop`, cycle 2 issues slot 1 + `lnop`, `fetch_ready`=0 in cycle 1.
- Slot 0 odd, slot 1 even, `cand_dep`=1 → slot 0 issues with `first_odd`=1 and `pc`=pair pc, then slot 1 issues the next cycle.
- `stall_even_raw` held 3 cycles with slot 0 even → 3 cycles of NOPs, `stall_cnt`=3, then issue on the 4th edge.
- `branch_taken` in SECOND with `fetch_valid`=1 → slot 1 discarded, NOPs issued, fetch not accepted, state EMPTY. The next pair is accepted one cycle later.
